// File: rtl/spc3_pkg.sv
// Shared types, error codes and frame-geometry helpers for the spc3 serial configuration port.
package spc3_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFull,
        StErr
    } state_e;

    localparam logic [1:0] ErrNone = 2'b00;
    localparam logic [1:0] ErrLen  = 2'b01;
    localparam logic [1:0] ErrPar  = 2'b10;
    localparam logic [1:0] ErrAddr = 2'b11;

    function automatic int unsigned addr_w(input int unsigned nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic int unsigned frame_len(input int unsigned width, input int unsigned nch);
        return width + addr_w(nch) + 1;
    endfunction

endpackage

// File: rtl/spc3_cfg_if.sv
// Serial configuration link between a board controller (master) and the spc3 port (slave).
interface spc3_cfg_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 4
);
    logic                   Cfg_in;
    logic                   Cfg_en;
    logic                   Strobe;
    logic                   Cfg_out;
    logic [NCH*WIDTH-1:0]   Cfg_q;
    logic                   Done;
    logic                   Err;
    logic [1:0]             Err_code;

    modport master (
        output Cfg_in, Cfg_en, Strobe,
        input  Cfg_out, Cfg_q, Done, Err, Err_code
    );

    modport slave (
        input  Cfg_in, Cfg_en, Strobe,
        output Cfg_out, Cfg_q, Done, Err, Err_code
    );
endinterface

// File: rtl/spc3_sipo.sv
// Enabled LSB-first shift register with bit counter and running parity; sr[0] feeds the chain.
module spc3_sipo #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned FRAME  = WIDTH + ADDR_W + 1,
    parameter int unsigned CNT_W  = $clog2(FRAME + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_i,
    input  logic              start_i,
    input  logic              bit_i,
    output logic [WIDTH-1:0]  data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              par_o,
    output logic              ser_o
);

    logic [FRAME-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        par_d = par_q;
        if (shift_i) begin
            sr_d = {bit_i, sr_q[FRAME-1:1]};
            if (start_i) begin
                cnt_d = CNT_W'(1);
                par_d = bit_i;
            end else begin
                // Saturate so an over-long burst cannot wrap back into a valid count.
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                par_d = par_q ^ bit_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
        end
    end

    assign data_o = sr_q[WIDTH-1:0];
    assign addr_o = sr_q[WIDTH+ADDR_W-1:WIDTH];
    assign cnt_o  = cnt_q;
    assign par_o  = par_q;
    assign ser_o  = sr_q[0];

endmodule

// File: rtl/spc3_cfg.sv
// spc3 serial configuration port: frame FSM, validation and NCH channel registers.
module spc3_cfg
    import spc3_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      NCH      = 4,
    parameter logic [WIDTH-1:0] RST_WORD = '0
) (
    input logic       Clk,
    input logic       Resetn,
    spc3_cfg_if.slave bus
);

    localparam int unsigned AddrW = addr_w(NCH);
    localparam int unsigned Frame = frame_len(WIDTH, NCH);
    localparam int unsigned CntW  = $clog2(Frame + 1);
    localparam logic [AddrW:0] NchL = (AddrW + 1)'(NCH);

    logic [WIDTH-1:0] data;
    logic [AddrW-1:0] addr;
    logic [CntW-1:0]  cnt;
    logic             par;

    state_e               state_q, state_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [NCH*WIDTH-1:0] cfg_q, cfg_d;

    spc3_sipo #(
        .WIDTH  (WIDTH),
        .ADDR_W (AddrW),
        .FRAME  (Frame),
        .CNT_W  (CntW)
    ) u_sipo (
        .clk_i   (Clk),
        .rst_ni  (Resetn),
        .shift_i (bus.Cfg_en),
        .start_i (state_q == StIdle),
        .bit_i   (bus.Cfg_in),
        .data_o  (data),
        .addr_o  (addr),
        .cnt_o   (cnt),
        .par_o   (par),
        .ser_o   (bus.Cfg_out)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        cfg_d   = cfg_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Cfg_en) begin
                    state_d = StShift;
                    code_d  = ErrNone;
                end
            end
            StShift: begin
                if (bus.Strobe || !bus.Cfg_en) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = ErrLen;
                end else if (cnt == CntW'(Frame - 1)) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (bus.Cfg_en) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = ErrLen;
                end else if (bus.Strobe) begin
                    if (par) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = ErrPar;
                    end else if ({1'b0, addr} >= NchL) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = ErrAddr;
                    end else begin
                        for (int k = 0; k < int'(NCH); k++) begin
                            if (int'(addr) == k) cfg_d[k*WIDTH +: WIDTH] = data;
                        end
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StErr: begin
                if (!bus.Cfg_en && !bus.Strobe) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
            cfg_q   <= {NCH{RST_WORD}};
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cfg_q   <= cfg_d;
        end
    end

    assign bus.Cfg_q    = cfg_q;
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
    assign bus.Err_code = code_q;

endmodule
